steak_grill_tracker: RTL and testbench

Consumes the one-cycle 1 Hz `go` tick produced by the grill tick generator and tracks the cooking state of one steak on the grill. It counts seconds cooked on each side, handles place/flip/serve player actions and detects burning. On serve or burn it emits a one-cycle scored doneness result for the game scoring logic.

---
 rtl/steak_pkg.sv | 33 +++
 rtl/steak_grill_tracker.sv | 124 ++++++++++++
 tb/tb_steak_grill_tracker.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/steak_pkg.sv
// Shared encodings for the steak grill tracker: FSM states, doneness codes
// and the min-side doneness classifier.
package steak_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COOKING = 2'd1,
        ST_BURNT   = 2'd2
    } grill_state_t;

    localparam logic [2:0] DN_RAW    = 3'd0;
    localparam logic [2:0] DN_RARE   = 3'd1;
    localparam logic [2:0] DN_MEDIUM = 3'd2;
    localparam logic [2:0] DN_WELL   = 3'd3;
    localparam logic [2:0] DN_BURNT  = 3'd4;

    // The steak is only as done as its least-cooked side.
    function automatic logic [2:0] classify(input int secs_a, input int secs_b,
                                            input int rare_s, input int medium_s,
                                            input int well_s);
        int m;
        m = (secs_a < secs_b) ? secs_a : secs_b;
        if (m < rare_s)
            return DN_RAW;
        else if (m < medium_s)
            return DN_RARE;
        else if (m < well_s)
            return DN_MEDIUM;
        else
            return DN_WELL;
    endfunction

endpackage

// File: rtl/steak_grill_tracker.sv
// Tracks one steak on the grill: per-side seconds, place/flip/serve handling,
// burn detection and a one-cycle scored doneness strobe.
module steak_grill_tracker
    import steak_pkg::*;
#(
    parameter int RARE_S   = 4,
    parameter int MEDIUM_S = 7,
    parameter int WELL_S   = 10,
    parameter int BURN_S   = 13,
    parameter int CNT_W    = 5
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             go,
    input  logic             place,
    input  logic             flip,
    input  logic             serve,
    output logic [1:0]       state,
    output logic             side_down,
    output logic [CNT_W-1:0] secs_a,
    output logic [CNT_W-1:0] secs_b,
    output logic             score_valid,
    output logic [2:0]       score
);

    localparam logic [CNT_W-1:0] BURN_C = CNT_W'(BURN_S);

    grill_state_t     state_p0, state_p1;
    logic             side_p0, side_p1;
    logic [CNT_W-1:0] secs_a_p0, secs_a_p1;
    logic [CNT_W-1:0] secs_b_p0, secs_b_p1;
    logic             vld_p0, vld_p1;
    logic [2:0]       score_p0, score_p1;

    // Saturates at the burn threshold so a counter can never wrap.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == BURN_C) ? v : v + 1'b1;
    endfunction

    // Stage p0: next-state and next-output decode from registered state
    always_comb begin
        state_p0  = state_p1;
        side_p0   = side_p1;
        secs_a_p0 = secs_a_p1;
        secs_b_p0 = secs_b_p1;
        vld_p0    = 1'b0;
        score_p0  = DN_RAW;
        case (state_p1)
            ST_IDLE: begin
                if (place) begin
                    state_p0  = ST_COOKING;
                    side_p0   = 1'b0;
                    secs_a_p0 = '0;
                    secs_b_p0 = '0;
                end
            end
            ST_COOKING: begin
                if (serve) begin
                    state_p0 = ST_IDLE;
                    vld_p0   = 1'b1;
                    score_p0 = classify(int'(secs_a_p1), int'(secs_b_p1),
                                        RARE_S, MEDIUM_S, WELL_S);
                end else begin
                    // The tick lands on the side that was down before any flip.
                    if (go) begin
                        if (side_p1) begin
                            secs_b_p0 = sat_inc(secs_b_p1);
                            if (secs_b_p0 == BURN_C) state_p0 = ST_BURNT;
                        end else begin
                            secs_a_p0 = sat_inc(secs_a_p1);
                            if (secs_a_p0 == BURN_C) state_p0 = ST_BURNT;
                        end
                        if (state_p0 == ST_BURNT) begin
                            vld_p0   = 1'b1;
                            score_p0 = DN_BURNT;
                        end
                    end
                    if (flip) side_p0 = ~side_p1;
                end
            end
            ST_BURNT: begin
                if (place) begin
                    state_p0  = ST_COOKING;
                    side_p0   = 1'b0;
                    secs_a_p0 = '0;
                    secs_b_p0 = '0;
                end else if (serve) begin
                    state_p0 = ST_IDLE;
                end
            end
            default: state_p0 = ST_IDLE;
        endcase
    end

    // Stage p1: registered FSM state
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_p1 <= ST_IDLE;
        else         state_p1 <= state_p0;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            side_p1   <= 1'b0;
            secs_a_p1 <= '0;
            secs_b_p1 <= '0;
            vld_p1    <= 1'b0;
            score_p1  <= DN_RAW;
        end else begin
            side_p1   <= side_p0;
            secs_a_p1 <= secs_a_p0;
            secs_b_p1 <= secs_b_p0;
            vld_p1    <= vld_p0;
            score_p1  <= score_p0;
        end
    end

    assign state       = state_p1;
    assign side_down   = side_p1;
    assign secs_a      = secs_a_p1;
    assign secs_b      = secs_b_p1;
    assign score_valid = vld_p1;
    assign score       = score_p1;

endmodule

// File: tb/tb_steak_grill_tracker.sv
// Directed and randomized bench for steak_grill_tracker against a behavioural
// model of the steak's life on the grill.
module tb_steak_grill_tracker;

    localparam int RARE_S   = 4;
    localparam int MEDIUM_S = 7;
    localparam int WELL_S   = 10;
    localparam int BURN_S   = 13;
    localparam int CNT_W    = 5;

    logic             clk = 1'b0;
    logic             resetn = 1'b0;
    logic             go = 1'b0, place = 1'b0, flip = 1'b0, serve = 1'b0;
    logic [1:0]       state;
    logic             side_down;
    logic [CNT_W-1:0] secs_a, secs_b;
    logic             score_valid;
    logic [2:0]       score;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: where the steak is, which side faces the fire,
    // seconds per side, and the result reported after the last edge.
    int m_where;      // 0 = grill empty, 1 = cooking, 2 = burnt
    int m_side;
    int m_secs[2];
    int m_sv;
    int m_score;

    steak_grill_tracker #(
        .RARE_S(RARE_S), .MEDIUM_S(MEDIUM_S), .WELL_S(WELL_S),
        .BURN_S(BURN_S), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .resetn(resetn), .go(go), .place(place), .flip(flip),
        .serve(serve), .state(state), .side_down(side_down), .secs_a(secs_a),
        .secs_b(secs_b), .score_valid(score_valid), .score(score)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int grade(input int a, input int b);
        int m;
        m = (a < b) ? a : b;
        if (m >= WELL_S)   return 3;
        if (m >= MEDIUM_S) return 2;
        if (m >= RARE_S)   return 1;
        return 0;
    endfunction

    task automatic model_reset();
        m_where = 0; m_side = 0; m_secs[0] = 0; m_secs[1] = 0;
        m_sv = 0; m_score = 0;
    endtask

    task automatic model_step(input bit p, input bit f, input bit g, input bit s);
        m_sv = 0;
        m_score = 0;
        if (m_where == 0) begin
            if (p) begin
                m_where = 1; m_side = 0; m_secs[0] = 0; m_secs[1] = 0;
            end
        end else if (m_where == 1) begin
            if (s) begin
                m_sv = 1;
                m_score = grade(m_secs[0], m_secs[1]);
                m_where = 0;
            end else begin
                if (g) begin
                    m_secs[m_side] = m_secs[m_side] + 1;
                    if (m_secs[m_side] == BURN_S) begin
                        m_where = 2; m_sv = 1; m_score = 4;
                    end
                end
                if (f) m_side = 1 - m_side;
            end
        end else begin
            if (p) begin
                m_where = 1; m_side = 0; m_secs[0] = 0; m_secs[1] = 0;
            end else if (s) begin
                m_where = 0;
            end
        end
    endtask

    task automatic check_all(input string tag);
        check_eq({tag, ".state"},  int'(state),       m_where);
        check_eq({tag, ".side"},   int'(side_down),   m_side);
        check_eq({tag, ".secs_a"}, int'(secs_a),      m_secs[0]);
        check_eq({tag, ".secs_b"}, int'(secs_b),      m_secs[1]);
        check_eq({tag, ".vld"},    int'(score_valid), m_sv);
        check_eq({tag, ".score"},  int'(score),       m_score);
    endtask

    // One clock: drive inputs, step the model at the edge, compare just after it.
    task automatic cycle(input bit p, input bit f, input bit g, input bit s,
                         input string tag);
        place = p; flip = f; go = g; serve = s;
        @(posedge clk);
        model_step(p, f, g, s);
        #1;
        check_all(tag);
        place = 1'b0; flip = 1'b0; go = 1'b0; serve = 1'b0;
    endtask

    task automatic gos(input int n, input string tag);
        for (int i = 0; i < n; i++) cycle(0, 0, 1, 0, tag);
    endtask

    // Reset asserted between edges must clear outputs without any clock edge.
    task automatic async_reset(input string tag);
        place = 1'b0; flip = 1'b0; go = 1'b0; serve = 1'b0;
        @(posedge clk);
        #2 resetn = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        @(posedge clk);
        #1 resetn = 1'b1;
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        resetn = 1'b1;

        // Test plan 1: 5 s on A, flip, 6 s on B, serve -> rare
        cycle(1, 0, 0, 0, "t1_place");
        gos(5, "t1_go_a");
        cycle(0, 1, 0, 0, "t1_flip");
        gos(6, "t1_go_b");
        cycle(0, 0, 0, 1, "t1_serve");
        check_eq("t1_score_rare", int'(score), 1);
        check_eq("t1_secs_a", int'(secs_a), 5);
        check_eq("t1_secs_b", int'(secs_b), 6);
        check_eq("t1_idle", int'(state), 0);
        cycle(0, 0, 0, 0, "t1_after");
        check_eq("t1_vld_one_cycle", int'(score_valid), 0);

        // Test plan 2: burn side A, then counters freeze
        cycle(1, 0, 0, 0, "t2_place");
        gos(13, "t2_go");
        check_eq("t2_burnt", int'(state), 2);
        check_eq("t2_score_burnt", int'(score), 4);
        check_eq("t2_secs_a", int'(secs_a), 13);
        gos(2, "t2_frozen");
        check_eq("t2_secs_a_frozen", int'(secs_a), 13);
        check_eq("t2_no_restrobe", int'(score_valid), 0);
        // Restart from BURNT, burn again, serve without strobe
        cycle(1, 0, 0, 0, "t2_replace");
        check_eq("t2_replace_secs_a", int'(secs_a), 0);
        check_eq("t2_replace_cooking", int'(state), 1);
        gos(13, "t2_reburn");
        cycle(0, 0, 0, 1, "t2_serve_burnt");
        check_eq("t2_serve_no_vld", int'(score_valid), 0);
        check_eq("t2_serve_idle", int'(state), 0);

        // Test plan 3: go and flip together
        cycle(1, 0, 0, 0, "t3_place");
        gos(3, "t3_go");
        cycle(0, 1, 1, 0, "t3_goflip");
        check_eq("t3_secs_a", int'(secs_a), 4);
        check_eq("t3_secs_b", int'(secs_b), 0);
        check_eq("t3_side", int'(side_down), 1);
        cycle(0, 0, 0, 1, "t3_serve");

        // Test plan 4: serve wins over a same-cycle go
        cycle(1, 0, 0, 0, "t4_place");
        gos(10, "t4_go_a");
        cycle(0, 1, 0, 0, "t4_flip");
        gos(10, "t4_go_b");
        cycle(0, 0, 1, 1, "t4_serve_go");
        check_eq("t4_score_well", int'(score), 3);
        check_eq("t4_secs_b", int'(secs_b), 10);
        check_eq("t4_idle", int'(state), 0);

        // Held place restarts only once
        for (int i = 0; i < 4; i++) cycle(1, 0, 1, 0, "held_place");
        check_eq("held_place_secs_a", int'(secs_a), 3);
        cycle(0, 0, 0, 1, "held_serve");

        // Test plan 5: reset mid-cook, go ignored afterwards
        cycle(1, 0, 0, 0, "t5_place");
        gos(6, "t5_go");
        async_reset("t5_reset");
        cycle(0, 0, 1, 0, "t5_go_after");
        check_eq("t5_secs_a_zero", int'(secs_a), 0);

        // Randomized traffic with occasional asynchronous resets
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 599) == 0)
                async_reset("rnd_reset");
            else
                cycle($urandom_range(0, 99) < 8, $urandom_range(0, 99) < 12,
                      $urandom_range(0, 99) < 50, $urandom_range(0, 99) < 4,
                      "rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
